ccd_line_capture: RTL and testbench

//  Parametrised successor to the fixed CCD timing + ADC capture pair: one block generates ROG/SH/cdsclk1/cdsclk2/adcclk
//  for a linear CCD and captures the AD9235-class parallel ADC word per pixel. Pixels stream out on a valid/ready port.

---
 rtl/ccd_pkg.sv | 37 +++
 rtl/ccd_line_capture_if.sv | 12 +
 rtl/ccd_pix_phase.sv | 44 ++++
 rtl/ccd_line_capture.sv | 227 ++++++++++++++++++++++
 tb/tb_ccd_line_capture.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ccd_pkg.sv
// Shared types and helpers for the linear-CCD line capture block.
// The line sequencer's state encoding, pixel-phase decode helpers and
// the width of the shared ROG/SETTLE/GAP cycle counter.
package ccd_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ROG,
    S_SETTLE,
    S_LINE,
    S_GAP
  } state_t;

  // Wide enough for ROG_W, SETTLE and GAP_PIX*DIV in any sensible build.
  localparam int CYC_W = 16;

  // sh and adcclk are high for the first half of each pixel period.
  function automatic logic ph_first_half(input int ph, input int div);
    return ph < div / 2;
  endfunction

  // CDS reset-level sample sits just after the shift-clock rising edge.
  function automatic logic ph_cds_reset(input int ph);
    return ph == 1;
  endfunction

  // CDS video-level sample sits just after the shift-clock falling edge.
  function automatic logic ph_cds_video(input int ph, input int div);
    return ph == div / 2 + 1;
  endfunction

  // The ADC word is taken on the last phase of the pixel period.
  function automatic logic ph_capture(input int ph, input int div);
    return ph == div - 1;
  endfunction

endpackage

// File: rtl/ccd_line_capture_if.sv
// Pixel stream port: valid/ready handshake with an end-of-line marker.
interface ccd_line_capture_if #(
  parameter int DATA_W = 12
);
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;
  logic              last;

  modport master (output data, valid, last, input ready);
  modport slave  (input data, valid, last, output ready);
endinterface

// File: rtl/ccd_pix_phase.sv
// Pixel-period phase counter and CCD/CDS/ADC clock decode.
// All clock outputs are low whenever en is low; strobe marks the capture phase.
module ccd_pix_phase
  import ccd_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sh,
  output logic adcclk,
  output logic cdsclk1,
  output logic cdsclk2,
  output logic strobe
);

  localparam int PH_W = $clog2(DIV);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(DIV - 1);

  logic [PH_W-1:0] ph;

  // Phase counter: wraps every DIV cycles, parked at 0 while disabled.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph <= '0;
    end else if (!en || ph == PH_LAST) begin
      ph <= '0;
    end else begin
      ph <= ph + 1'b1;
    end
  end

  // Clock decode straight from the phase register and the registered enable.
  always_comb begin
    sh      = en && ph_first_half(int'(ph), DIV);
    adcclk  = en && ph_first_half(int'(ph), DIV);
    cdsclk1 = en && ph_cds_reset(int'(ph));
    cdsclk2 = en && ph_cds_video(int'(ph), DIV);
    strobe  = en && ph_capture(int'(ph), DIV);
  end

endmodule

// File: rtl/ccd_line_capture.sv
// Linear-CCD timing generator and parallel ADC capture.
// Sequences ROG -> SETTLE -> LINE -> GAP, drives the CCD/CDS/ADC clocks, and
// streams active pixels through a 1-deep holding register on a valid/ready port.
// Optional build macro CCD_DARK_CLAMP_EN: subtract the mean of the dummy
// pixels from every active pixel, clamped at zero.
module ccd_line_capture
  import ccd_pkg::*;
#(
  parameter int DATA_W    = 12,
  parameter int PIX_NUM   = 2048,
  parameter int DUMMY_NUM = 32,
  parameter int DIV       = 4,
  parameter int ROG_W     = 16,
  parameter int SETTLE    = 8,
  parameter int GAP_PIX   = 16,
  parameter int ADC_LAT   = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] adc_data,
  output logic              rog,
  output logic              sh,
  output logic              cdsclk1,
  output logic              cdsclk2,
  output logic              adcclk,
  output logic              busy,
  output logic              overflow,
  ccd_line_capture_if.master pix
);

  // Pixel periods per line: dummies, actives, then ADC pipeline flush.
  localparam int T   = DUMMY_NUM + PIX_NUM + ADC_LAT;
  localparam int P_W = $clog2(T);

  localparam logic [P_W-1:0]   P_LAST      = P_W'(T - 1);
  localparam logic [CYC_W-1:0] ROG_LAST    = CYC_W'(ROG_W - 1);
  localparam logic [CYC_W-1:0] SETTLE_LAST = CYC_W'(SETTLE - 1);
  localparam logic [CYC_W-1:0] GAP_LAST    = CYC_W'(GAP_PIX * DIV - 1);
  localparam int               K_LAST      = DUMMY_NUM + PIX_NUM - 1;

  state_t           state;
  logic [CYC_W-1:0] cyc;
  logic [P_W-1:0]   p;
  logic             line_en;
  logic             strobe;

  assign line_en = (state == S_LINE);

  ccd_pix_phase #(
    .DIV (DIV)
  ) u_phase (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (line_en),
    .sh      (sh),
    .adcclk  (adcclk),
    .cdsclk1 (cdsclk1),
    .cdsclk2 (cdsclk2),
    .strobe  (strobe)
  );

  // Line sequencer with registered rog/busy; start only matters in IDLE and at end of GAP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cyc   <= '0;
      p     <= '0;
      rog   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_ROG;
            cyc   <= '0;
            rog   <= 1'b1;
            busy  <= 1'b1;
          end
        end
        S_ROG: begin
          if (cyc == ROG_LAST) begin
            state <= S_SETTLE;
            cyc   <= '0;
            rog   <= 1'b0;
          end else begin
            cyc <= cyc + 1'b1;
          end
        end
        S_SETTLE: begin
          if (cyc == SETTLE_LAST) begin
            state <= S_LINE;
            cyc   <= '0;
            p     <= '0;
          end else begin
            cyc <= cyc + 1'b1;
          end
        end
        S_LINE: begin
          if (strobe) begin
            if (p == P_LAST) begin
              state <= S_GAP;
              p     <= '0;
            end else begin
              p <= p + 1'b1;
            end
          end
        end
        S_GAP: begin
          if (cyc == GAP_LAST) begin
            cyc <= '0;
            if (start) begin
              state <= S_ROG;
              rog   <= 1'b1;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cyc <= cyc + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          rog   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Pixel index of the word the ADC presents now; negative while the pipeline fills.
  int   k;
  logic cap_hit;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    k       = int'(p) - ADC_LAT;
    cap_hit = line_en && strobe && (k >= 0);
  end

  logic              cap_pend;
  logic [DATA_W-1:0] cap_data;
  logic              cap_last;
  logic [DATA_W-1:0] out_data;

  // Capture stage: register the ADC word; only active pixels request the holding register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_pend <= 1'b0;
      cap_data <= '0;
      cap_last <= 1'b0;
    end else begin
      cap_pend <= cap_hit && (k >= DUMMY_NUM);
      if (cap_hit) begin
        cap_data <= adc_data;
        cap_last <= (k == K_LAST);
      end
    end
  end

`ifdef CCD_DARK_CLAMP_EN
  localparam int LOG_D = $clog2(DUMMY_NUM);
  localparam int SUM_W = DATA_W + LOG_D;

  logic [SUM_W-1:0]  dark_sum;
  logic [SUM_W-1:0]  sum_next;
  logic [DATA_W-1:0] dark_mean;

  assign sum_next = dark_sum + SUM_W'(adc_data);

  // Dark accumulator: cleared during ROG, mean latched with the last dummy pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dark_sum  <= '0;
      dark_mean <= '0;
    end else if (state == S_ROG) begin
      dark_sum <= '0;
    end else if (cap_hit && (k < DUMMY_NUM)) begin
      dark_sum <= sum_next;
      if (k == DUMMY_NUM - 1) begin
        dark_mean <= DATA_W'(sum_next >> LOG_D);
      end
    end
  end

  assign out_data = (cap_data > dark_mean) ? (cap_data - dark_mean) : '0;
`else
  assign out_data = cap_data;
`endif

  logic              hold_valid;
  logic [DATA_W-1:0] hold_data;
  logic              hold_last;
  logic              drain;

  assign drain = hold_valid && pix.ready;

  // Holding register: a write lands if empty or draining this cycle, otherwise it is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
      hold_last  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      overflow <= 1'b0;
      if (drain) begin
        hold_valid <= 1'b0;
      end
      if (cap_pend) begin
        if (!hold_valid || drain) begin
          hold_valid <= 1'b1;
          hold_data  <= out_data;
          hold_last  <= cap_last;
        end else begin
          overflow <= 1'b1;
        end
      end
    end
  end

  assign pix.valid = hold_valid;
  assign pix.data  = hold_data;
  assign pix.last  = hold_last;

endmodule

// File: tb/tb_ccd_line_capture.sv
// Directed bench for ccd_line_capture with a small CCD line
// (DIV=4, 4 dummies, 8 actives, ADC latency 2, ROG 3, SETTLE 2, GAP 2).
// Expected per-line busy time: 3 + 2 + 14*4 + 2*4 = 69 clk.
module tb_ccd_line_capture;

  localparam int DATA_W    = 12;
  localparam int PIX_NUM   = 8;
  localparam int DUMMY_NUM = 4;
  localparam int DIV       = 4;
  localparam int ROG_W     = 3;
  localparam int SETTLE    = 2;
  localparam int GAP_PIX   = 2;
  localparam int ADC_LAT   = 2;

`ifdef CCD_DARK_CLAMP_EN
  localparam int CLAMP_OFS = 1;  // dummy words 0,1,2,3 -> sum 6 -> mean 1
`else
  localparam int CLAMP_OFS = 0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [DATA_W-1:0] adc_data;
  logic              rog, sh, cdsclk1, cdsclk2, adcclk, busy, overflow;

  ccd_line_capture_if #(.DATA_W(DATA_W)) pix_if ();

  ccd_line_capture #(
    .DATA_W    (DATA_W),
    .PIX_NUM   (PIX_NUM),
    .DUMMY_NUM (DUMMY_NUM),
    .DIV       (DIV),
    .ROG_W     (ROG_W),
    .SETTLE    (SETTLE),
    .GAP_PIX   (GAP_PIX),
    .ADC_LAT   (ADC_LAT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .adc_data (adc_data),
    .rog      (rog),
    .sh       (sh),
    .cdsclk1  (cdsclk1),
    .cdsclk2  (cdsclk2),
    .adcclk   (adcclk),
    .busy     (busy),
    .overflow (overflow),
    .pix      (pix_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // ADC model: pixel n is sampled on the n-th adcclk rise after ROG and
  // presented ADC_LAT pixel periods later.
  bit                dark_mode = 1'b0;
  logic [DATA_W-1:0] dark_tab [8];
  logic [DATA_W-1:0] dark_exp [8];
  int                adc_n = 0;
  logic              adc_prev = 1'b0;

  always @(negedge clk) begin
    int k;
    if (rog) adc_n = 0;
    else if (adcclk && !adc_prev) adc_n++;
    adc_prev = adcclk;
    k = adc_n - 1 - ADC_LAT;
    if (dark_mode) begin
      if (k >= DUMMY_NUM && k < DUMMY_NUM + PIX_NUM) adc_data = dark_tab[k - DUMMY_NUM];
      else adc_data = 12'd100;
    end else begin
      adc_data = 12'(k);
    end
  end

  // Monitor: transfers, overflow pulses, busy time, ROG rise spacing.
  logic [DATA_W-1:0] got_q [$];
  bit                last_q [$];
  int                rise_cyc [$];
  int                gap_q [$];
  int                ovf_cnt, busy_cyc, cyc, last_sh_cyc;
  int                rog_rises;
  logic              rog_prev = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (pix_if.valid && pix_if.ready) begin
      got_q.push_back(pix_if.data);
      last_q.push_back(pix_if.last);
    end
    if (overflow) ovf_cnt++;
    if (busy) busy_cyc++;
    if (sh) last_sh_cyc = cyc;
    if (rog && !rog_prev) begin
      rog_rises++;
      rise_cyc.push_back(cyc);
      gap_q.push_back(cyc - last_sh_cyc);
    end
    rog_prev = rog;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    got_q.delete();
    last_q.delete();
    rise_cyc.delete();
    gap_q.delete();
    ovf_cnt     = 0;
    busy_cyc    = 0;
    rog_rises   = 0;
    last_sh_cyc = 0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_idle"}, busy, 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  function automatic logic [DATA_W-1:0] exp_pix(input int i);
    if (dark_mode) return dark_exp[i % PIX_NUM];
    return DATA_W'(DUMMY_NUM + (i % PIX_NUM) - CLAMP_OFS);
  endfunction

  task automatic check_pixels(input string tag, input int n);
    check({tag, "_count"}, got_q.size(), n);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_data%0d", tag, i),
            (i < got_q.size()) ? 32'(got_q[i]) : 32'hFFFF_FFFF, 32'(exp_pix(i)));
      check($sformatf("%s_last%0d", tag, i),
            (i < last_q.size()) ? 32'(last_q[i]) : 32'hFFFF_FFFF, ((i % PIX_NUM) == PIX_NUM - 1) ? 1 : 0);
    end
  endtask

  initial begin
    logic [3:0] sh_pat, adc_pat, c1_pat, c2_pat;
    int w, n;

    rst_n = 1'b0;
    start = 1'b0;
    pix_if.ready = 1'b1;
    dark_tab = '{12'd90, 12'd99, 12'd100, 12'd101, 12'd120, 12'd130, 12'd150, 12'd160};
    dark_exp = '{12'd0, 12'd0, 12'd0, 12'd1, 12'd20, 12'd30, 12'd50, 12'd60};

    // Reset state
    repeat (3) tick();
    check("rst_outs", {rog, sh, cdsclk1, cdsclk2, adcclk, busy, overflow, pix_if.valid, pix_if.last}, 0);
    check("rst_data", pix_if.data, 0);
    rst_n = 1'b1;
    tick();
    clear_mon();

    // Single line with 1-clk start pulse, plus waveform shape
    pulse_start();
    check("t1_busy", busy, 1);
    check("t4_clks_off_in_rog", {sh, adcclk, cdsclk1, cdsclk2}, 0);
    w = 0;
    while (rog && w < 20) begin
      w++;
      tick();
    end
    check("t4_rog_width", w, 3);
    n = 0;
    while (!sh && n < 20) begin
      tick();
      n++;
    end
    check("t4_line_started", sh, 1);
    for (int i = 0; i < DIV; i++) begin
      sh_pat  = {sh_pat[2:0], sh};
      adc_pat = {adc_pat[2:0], adcclk};
      c1_pat  = {c1_pat[2:0], cdsclk1};
      c2_pat  = {c2_pat[2:0], cdsclk2};
      tick();
    end
    check("t4_sh", sh_pat, 4'b1100);
    check("t4_adcclk", adc_pat, 4'b1100);
    check("t4_cdsclk1", c1_pat, 4'b0100);
    check("t4_cdsclk2", c2_pat, 4'b0001);
    wait_idle("t1", 200);
    check_pixels("t1", 8);
    check("t1_overflow", ovf_cnt, 0);
    check("t1_busy_cycles", busy_cyc, 69);
    clear_mon();

    // Start held high: three back-to-back lines
    start = 1'b1;
    n = 0;
    while (rog_rises < 3 && n < 400) begin
      tick();
      n++;
    end
    check("t2_rog_rises", rog_rises, 3);
    start = 1'b0;
    wait_idle("t2", 200);
    check_pixels("t2", 24);
    check("t2_overflow", ovf_cnt, 0);
    check("t2_busy_cycles", busy_cyc, 3 * 69);
    check("t2_line_period1", rise_cyc[1] - rise_cyc[0], 69);
    check("t2_line_period2", rise_cyc[2] - rise_cyc[1], 69);
    // last sh-high is ph1 of the last period: ph2, ph3, 8 GAP clk, then ROG
    check("t2_gap1", gap_q[1], 11);
    check("t2_gap2", gap_q[2], 11);
    clear_mon();

    // Downstream stalled for the whole line
    pix_if.ready = 1'b0;
    pulse_start();
    check("t3_busy", busy, 1);
    wait_idle("t3", 200);
    check("t3_overflow", ovf_cnt, 7);
    check("t3_busy_cycles", busy_cyc, 69);
    check("t3_valid_held", pix_if.valid, 1);
    check("t3_data_held", pix_if.data, 4 - CLAMP_OFS);
    check("t3_last_held", pix_if.last, 0);
    check("t3_no_xfer", got_q.size(), 0);
    pix_if.ready = 1'b1;
    tick();
    check("t3_drain_count", got_q.size(), 1);
    check("t3_drain_data", (got_q.size() > 0) ? 32'(got_q[0]) : 32'hFFFF_FFFF, 4 - CLAMP_OFS);
    check("t3_valid_after", pix_if.valid, 0);
    clear_mon();

    // Asynchronous reset mid-line, then a clean restart
    pulse_start();
    n = 0;
    while (got_q.size() < 3 && n < 300) begin
      tick();
      n++;
    end
    check("t5_mid_line", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_outs", {rog, sh, cdsclk1, cdsclk2, adcclk, busy, overflow, pix_if.valid, pix_if.last}, 0);
    check("t5_async_data", pix_if.data, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    clear_mon();
    pulse_start();
    wait_idle("t5", 200);
    check_pixels("t5", 8);
    check("t5_overflow", ovf_cnt, 0);
    clear_mon();

`ifdef CCD_DARK_CLAMP_EN
    // Dark clamp: dummies 100, actives straddle the mean
    dark_mode = 1'b1;
    pulse_start();
    wait_idle("t6", 200);
    check_pixels("t6", 8);
    dark_mode = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
